// File: rtl/videoctl_pkg.sv
// Shared constants for the video controller register bank: control-region
// offsets, CTL/STATUS/IRQEN bit positions and display mode encodings.
package videoctl_pkg;

  localparam logic [3:0] REG_BASE_HI   = 4'h0;
  localparam logic [3:0] REG_BASE_LO   = 4'h1;
  localparam logic [3:0] REG_LEFT_HI   = 4'h2;
  localparam logic [3:0] REG_LEFT_LO   = 4'h3;
  localparam logic [3:0] REG_RIGHT_HI  = 4'h4;
  localparam logic [3:0] REG_RIGHT_LO  = 4'h5;
  localparam logic [3:0] REG_TOP_HI    = 4'h6;
  localparam logic [3:0] REG_TOP_LO    = 4'h7;
  localparam logic [3:0] REG_BOTTOM_HI = 4'h8;
  localparam logic [3:0] REG_BOTTOM_LO = 4'h9;
  localparam logic [3:0] REG_MODE      = 4'hA;
  localparam logic [3:0] REG_CTL       = 4'hB;
  localparam logic [3:0] REG_STATUS    = 4'hC;
  localparam logic [3:0] REG_CMP_HI    = 4'hD;
  localparam logic [3:0] REG_CMP_LO    = 4'hE;
  localparam logic [3:0] REG_IRQEN     = 4'hF;

  localparam int CTL_COMMIT    = 0;
  localparam int CTL_IMMEDIATE = 1;

  localparam int STAT_PENDING  = 0;
  localparam int STAT_VBLANK   = 1;
  localparam int STAT_IRQ      = 2;

  localparam int IRQEN_VBLANK  = 0;
  localparam int IRQEN_RASTER  = 1;

  localparam logic [1:0] MODE_TEXT = 2'd0;
  localparam logic [1:0] MODE_1BPP = 2'd1;
  localparam logic [1:0] MODE_2BPP = 2'd2;
  localparam logic [1:0] MODE_4BPP = 2'd3;

endpackage

// File: rtl/videoctl_regfile_sync_falling_edge.sv
// Two-flop synchroniser for an active-low sync strobe from the pixel domain,
// with a one-cycle pulse on its synchronised falling edge.
module sync_falling_edge (
  input  logic clk_i,
  input  logic nreset_i,
  input  logic d_i,
  output logic sync_o,
  output logic fall_o
);

  logic s1_q, s2_q, prev_q;

  // Idle-high reset level keeps a freshly reset bank from seeing a false edge.
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign sync_o = s2_q;
  assign fall_o = prev_q & ~s2_q;

endmodule

// File: rtl/videoctl_regfile.sv
// Double-buffered viewport/mode/palette register bank, committed at vsync.
// Build option VIDEOCTL_RASTER_IRQ_EN adds the line counter and raster IRQ.
module videoctl_regfile
  import videoctl_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int PAL_BITS = 4,
  parameter int COLOR_W  = 8,
  parameter int POS_W    = 10
) (
  input  logic                 reg_clk,
  input  logic                 nreset,
  input  logic                 reg_wr,
  input  logic                 reg_rd,
  input  logic [ADDR_W-1:0]    reg_addr,
  input  logic [7:0]           reg_data,
  output logic [7:0]           reg_q,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  output logic [15:0]          base_addr,
  output logic [POS_W-1:0]     vp_left,
  output logic [POS_W-1:0]     vp_right,
  output logic [POS_W-1:0]     vp_top,
  output logic [POS_W-1:0]     vp_bottom,
  output logic [1:0]           mode,
  output logic [1:0]           hzoom_max,
  output logic [1:0]           vzoom_max,
  input  logic [PAL_BITS-1:0]  pal_idx,
  output logic [3*COLOR_W-1:0] pal_rgb,
  output logic                 irq
);

  localparam int NPAL = 1 << PAL_BITS;
  localparam int HI_W = POS_W - 8;
  localparam int CW   = ADDR_W - 1 - PAL_BITS;

  logic               hs_sync, hs_fall, vs_sync, vs_fall;
  logic               ctl_sel, pal_sel, pal_ok, wr_reg, wr_pal;
  logic [3:0]         off;
  logic [1:0]         vp_sel;
  logic [CW-1:0]      pal_comp;
  logic [1:0]         comp2;
  logic [PAL_BITS-1:0] pal_ent;
  logic               commit, load_act, raster_hit;

  logic [15:0]        base_w_q, base_a_q;
  logic [5:0]         mode_w_q, mode_a_q;
  logic [POS_W-1:0]   vp_w_q [4];
  logic [POS_W-1:0]   vp_a_q [4];
  logic [COLOR_W-1:0] pal_w_q [3][NPAL];
  logic [COLOR_W-1:0] pal_a_q [3][NPAL];
  logic [1:0]         irqen_q;
  logic               pending_q, pending_d, imm_q, imm_d, irq_flag_q, irq_flag_d;
  logic [7:0]         rd_d;

  sync_falling_edge u_hsync (.clk_i(reg_clk), .nreset_i(nreset), .d_i(hsync_in),
                             .sync_o(hs_sync), .fall_o(hs_fall));
  sync_falling_edge u_vsync (.clk_i(reg_clk), .nreset_i(nreset), .d_i(vsync_in),
                             .sync_o(vs_sync), .fall_o(vs_fall));

  assign ctl_sel  = (reg_addr[ADDR_W-1:4] == '0);
  assign pal_sel  = reg_addr[ADDR_W-1];
  assign off      = reg_addr[3:0];
  assign vp_sel   = 2'(off[3:1] - 3'd1);
  assign pal_comp = reg_addr[ADDR_W-2:PAL_BITS];
  assign comp2    = 2'(pal_comp);
  assign pal_ent  = reg_addr[PAL_BITS-1:0];
  assign pal_ok   = pal_sel && (pal_comp < CW'(3));
  assign wr_reg   = reg_wr && ctl_sel;
  assign wr_pal   = reg_wr && pal_ok;

  // The active copy samples the pre-edge working copy, so a write landing on
  // the commit edge stays behind in the working copy for the next frame.
  assign commit   = vs_fall && pending_q;
  assign load_act = commit || imm_q;

  always_ff @(posedge reg_clk) begin
    if (!nreset) begin
      base_w_q <= '0;
      mode_w_q <= '0;
      irqen_q  <= '0;
      for (int i = 0; i < 4; i++) vp_w_q[i] <= '0;
    end else if (wr_reg) begin
      case (off)
        REG_BASE_HI: base_w_q[15:8] <= reg_data;
        REG_BASE_LO: base_w_q[7:0]  <= reg_data;
        REG_LEFT_HI, REG_RIGHT_HI, REG_TOP_HI, REG_BOTTOM_HI:
          vp_w_q[vp_sel][POS_W-1:8] <= reg_data[HI_W-1:0];
        REG_LEFT_LO, REG_RIGHT_LO, REG_TOP_LO, REG_BOTTOM_LO:
          vp_w_q[vp_sel][7:0] <= reg_data;
        REG_MODE: mode_w_q <= reg_data[5:0];
`ifdef VIDEOCTL_RASTER_IRQ_EN
        REG_IRQEN: irqen_q <= reg_data[1:0];
`else
        REG_IRQEN: irqen_q <= {1'b0, reg_data[IRQEN_VBLANK]};
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge reg_clk) begin
    if (!nreset) begin
      for (int c = 0; c < 3; c++)
        for (int i = 0; i < NPAL; i++) pal_w_q[c][i] <= '0;
    end else if (wr_pal) begin
      pal_w_q[comp2][pal_ent] <= reg_data[COLOR_W-1:0];
    end
  end

  always_ff @(posedge reg_clk) begin
    if (!nreset) begin
      base_a_q <= '0;
      mode_a_q <= '0;
      for (int i = 0; i < 4; i++) vp_a_q[i] <= '0;
      for (int c = 0; c < 3; c++)
        for (int i = 0; i < NPAL; i++) pal_a_q[c][i] <= '0;
    end else if (load_act) begin
      base_a_q <= base_w_q;
      mode_a_q <= mode_w_q;
      vp_a_q   <= vp_w_q;
      pal_a_q  <= pal_w_q;
    end
  end

`ifdef VIDEOCTL_RASTER_IRQ_EN
  logic [POS_W-1:0] cmp_q, line_q, line_d;

  always_ff @(posedge reg_clk) begin
    if (!nreset) begin
      cmp_q  <= '0;
      line_q <= '0;
    end else begin
      line_q <= line_d;
      if (wr_reg && off == REG_CMP_HI) cmp_q[POS_W-1:8] <= reg_data[HI_W-1:0];
      if (wr_reg && off == REG_CMP_LO) cmp_q[7:0] <= reg_data;
    end
  end

  // vsync restarts the frame and takes priority over a coincident hsync.
  always_comb begin
    line_d     = line_q;
    raster_hit = 1'b0;
    if (vs_fall) begin
      line_d = '0;
    end else if (hs_fall && line_q != '1) begin
      line_d     = line_q + POS_W'(1);
      raster_hit = irqen_q[IRQEN_RASTER] && (line_d == cmp_q);
    end
  end
`else
  assign raster_hit = 1'b0;
`endif

  always_comb begin
    pending_d  = pending_q;
    imm_d      = imm_q;
    irq_flag_d = irq_flag_q;
    if (wr_reg && off == REG_CTL) begin
      pending_d = reg_data[CTL_COMMIT];
      imm_d     = reg_data[CTL_IMMEDIATE];
    end else if (commit) begin
      pending_d = 1'b0;
    end
    if ((vs_fall && irqen_q[IRQEN_VBLANK]) || raster_hit)
      irq_flag_d = 1'b1;
    else if (wr_reg && off == REG_STATUS && reg_data[STAT_IRQ])
      irq_flag_d = 1'b0;
  end

  always_comb begin
    rd_d = '0;
    if (ctl_sel) begin
      case (off)
        REG_BASE_HI: rd_d = base_w_q[15:8];
        REG_BASE_LO: rd_d = base_w_q[7:0];
        REG_LEFT_HI, REG_RIGHT_HI, REG_TOP_HI, REG_BOTTOM_HI:
          rd_d = 8'(vp_w_q[vp_sel][POS_W-1:8]);
        REG_LEFT_LO, REG_RIGHT_LO, REG_TOP_LO, REG_BOTTOM_LO:
          rd_d = vp_w_q[vp_sel][7:0];
        REG_MODE:    rd_d = {2'b00, mode_w_q};
        REG_CTL:     rd_d = {6'd0, imm_q, pending_q};
        REG_STATUS: begin
          rd_d[STAT_PENDING] = pending_q;
          rd_d[STAT_VBLANK]  = ~vs_sync;
          rd_d[STAT_IRQ]     = irq_flag_q;
        end
`ifdef VIDEOCTL_RASTER_IRQ_EN
        REG_CMP_HI:  rd_d = 8'(cmp_q[POS_W-1:8]);
        REG_CMP_LO:  rd_d = cmp_q[7:0];
`endif
        REG_IRQEN:   rd_d = {6'd0, irqen_q};
        default: ;
      endcase
    end else if (pal_ok) begin
      rd_d = 8'(pal_w_q[comp2][pal_ent]);
    end
  end

  always_ff @(posedge reg_clk) begin
    if (!nreset) begin
      pending_q  <= 1'b0;
      imm_q      <= 1'b0;
      irq_flag_q <= 1'b0;
      reg_q      <= '0;
    end else begin
      pending_q  <= pending_d;
      imm_q      <= imm_d;
      irq_flag_q <= irq_flag_d;
      if (reg_rd) reg_q <= rd_d;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{hs_sync, hs_fall};

  assign base_addr = base_a_q;
  assign vp_left   = vp_a_q[0];
  assign vp_right  = vp_a_q[1];
  assign vp_top    = vp_a_q[2];
  assign vp_bottom = vp_a_q[3];
  assign mode      = mode_a_q[1:0];
  assign hzoom_max = mode_a_q[3:2];
  assign vzoom_max = mode_a_q[5:4];
  assign pal_rgb   = {pal_a_q[0][pal_idx], pal_a_q[1][pal_idx], pal_a_q[2][pal_idx]};
  assign irq       = irq_flag_q;

endmodule

// File: tb/tb_videoctl_regfile.sv
// Scoreboard bench for videoctl_regfile: a byte-map reference model predicts
// readback and display-side outputs under directed and random traffic.
module tb_videoctl_regfile;

  logic        reg_clk = 1'b0;
  logic        nreset = 1'b0;
  logic        reg_wr = 1'b0;
  logic        reg_rd = 1'b0;
  logic [6:0]  reg_addr = '0;
  logic [7:0]  reg_data = '0;
  logic [7:0]  reg_q;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [15:0] base_addr;
  logic [9:0]  vp_left, vp_right, vp_top, vp_bottom;
  logic [1:0]  mode, hzoom_max, vzoom_max;
  logic [3:0]  pal_idx = '0;
  logic [23:0] pal_rgb;
  logic        irq;

  videoctl_regfile dut (
    .reg_clk(reg_clk), .nreset(nreset), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_addr(reg_addr), .reg_data(reg_data), .reg_q(reg_q),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .base_addr(base_addr),
    .vp_left(vp_left), .vp_right(vp_right), .vp_top(vp_top), .vp_bottom(vp_bottom),
    .mode(mode), .hzoom_max(hzoom_max), .vzoom_max(vzoom_max),
    .pal_idx(pal_idx), .pal_rgb(pal_rgb), .irq(irq)
  );

  always #5 reg_clk = ~reg_clk;

  int checks = 0;
  int failures = 0;

  // Reference model: working and active copies as byte maps of the address space.
  bit [7:0] wmem [128];
  bit [7:0] amem [128];
  bit       pend, imm, flag;
  int       line;
  bit       v1 = 1, v2 = 1, v3 = 1, h1 = 1, h2 = 1, h3 = 1;
  bit       hs_v = 1, vs_v = 1;
  bit [3:0] pidx_v = '0;

  typedef struct { bit [6:0] a; bit [7:0] v; } rd_t;
  rd_t exp_q [$];
  bit  rd_vld = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic bit [7:0] wmask(input int a);
    case (a)
      0, 1, 3, 5, 7, 9: return 8'hFF;
      2, 4, 6, 8:       return 8'h03;
      10:               return 8'h3F;
`ifdef VIDEOCTL_RASTER_IRQ_EN
      13:               return 8'h03;
      14:               return 8'hFF;
      15:               return 8'h03;
`else
      15:               return 8'h01;
`endif
      default:          return (a >= 64 && a < 112) ? 8'hFF : 8'h00;
    endcase
  endfunction

  function automatic bit [7:0] rdval(input int a);
    if (a == 11) return {6'd0, imm, pend};
    if (a == 12) return {5'd0, flag, ~v2, pend};
    return wmem[a];
  endfunction

  task automatic check_outputs();
    chk("base_addr", base_addr, {amem[0], amem[1]});
    chk("vp_left",   vp_left,   {amem[2][1:0], amem[3]});
    chk("vp_right",  vp_right,  {amem[4][1:0], amem[5]});
    chk("vp_top",    vp_top,    {amem[6][1:0], amem[7]});
    chk("vp_bottom", vp_bottom, {amem[8][1:0], amem[9]});
    chk("mode",      mode,      amem[10][1:0]);
    chk("hzoom_max", hzoom_max, amem[10][3:2]);
    chk("vzoom_max", vzoom_max, amem[10][5:4]);
    chk("pal_rgb",   pal_rgb,   {amem[64 + pidx_v], amem[80 + pidx_v], amem[96 + pidx_v]});
    chk("irq",       irq,       flag);
  endtask

  // One bus cycle: drive inputs, predict the effect of the coming edge, then check.
  task automatic cyc(input bit wr, input bit rd, input bit [6:0] a, input bit [7:0] d);
    bit vfall, commit, rhit;
    reg_wr = wr; reg_rd = rd; reg_addr = a; reg_data = d;
    pal_idx = pidx_v; hsync_in = hs_v; vsync_in = vs_v;
    if (rd) exp_q.push_back('{a, rdval(a)});
    vfall  = v3 & ~v2;
    commit = vfall & pend;
    rhit   = 1'b0;
    if (imm || commit) amem = wmem;
`ifdef VIDEOCTL_RASTER_IRQ_EN
    begin
      int cmpv;
      cmpv = {wmem[13][1:0], wmem[14]};
      if (vfall) line = 0;
      else if ((h3 & ~h2) && line < 1023) begin
        line++;
        rhit = wmem[15][1] && (line == cmpv);
      end
    end
`endif
    if ((vfall && wmem[15][0]) || rhit) flag = 1'b1;
    else if (wr && a == 12 && d[2]) flag = 1'b0;
    if (wr && a == 11) begin pend = d[0]; imm = d[1]; end
    else if (commit) pend = 1'b0;
    if (wr && a != 11 && a != 12) wmem[a] = d & wmask(a);
    @(posedge reg_clk); #1;
    v3 = v2; v2 = v1; v1 = vs_v;
    h3 = h2; h2 = h1; h1 = hs_v;
    check_outputs();
  endtask

  task automatic do_wr(input bit [6:0] a, input bit [7:0] d); cyc(1'b1, 1'b0, a, d); endtask
  task automatic do_rd(input bit [6:0] a); cyc(1'b0, 1'b1, a, 8'h00); endtask
  task automatic idle(input int n); repeat (n) cyc(1'b0, 1'b0, 7'd0, 8'h00); endtask

  task automatic vsync_pulse();
    vs_v = 1'b0; idle(4);
    vs_v = 1'b1; idle(2);
  endtask

  task automatic hsync_pulse();
    hs_v = 1'b0; idle(1);
    hs_v = 1'b1; idle(3);
  endtask

  task automatic do_reset();
    nreset = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0;
    hs_v = 1'b1; vs_v = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    repeat (2) @(posedge reg_clk);
    #1;
    nreset = 1'b1;
    wmem = '{default: 8'h00}; amem = '{default: 8'h00};
    pend = 0; imm = 0; flag = 0; line = 0;
    v1 = 1; v2 = 1; v3 = 1; h1 = 1; h2 = 1; h3 = 1;
    chk("reset_reg_q", reg_q, 8'h00);
    check_outputs();
  endtask

  // Read-data monitor: reg_q is due the cycle after each read strobe.
  always @(posedge reg_clk) rd_vld <= reg_rd;

  always @(negedge reg_clk) begin
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        chk("rd_underflow", 1, 0);
      end else begin
        rd_t e;
        e = exp_q.pop_front();
        chk($sformatf("reg_q@%0h", e.a), reg_q, e.v);
      end
    end
  end

  function automatic bit [6:0] pick_addr();
    case ($urandom % 3)
      0:       return 7'($urandom % 16);
      1:       return 7'(64 + $urandom % 48);
      default: return 7'($urandom % 128);
    endcase
  endfunction

  initial begin
    do_reset();
    for (int a = 0; a < 16; a++) do_rd(7'(a));
    for (int a = 64; a < 112; a++) do_rd(7'(a));

    // Staged commit of vp_left at the next vsync.
    do_wr(7'h02, 8'h01); do_wr(7'h03, 8'h2C); do_wr(7'h0B, 8'h01);
    do_rd(7'h0C);
    chk("left_before_vsync", vp_left, 10'h000);
    vsync_pulse();
    chk("left_after_commit", vp_left, 10'h12C);
    do_rd(7'h0C);

    // Immediate mode: palette follows the working copy without vsync.
    pidx_v = 4'd5;
    do_wr(7'h0B, 8'h02); do_wr(7'h45, 8'hAA); idle(1);
    chk("pal_immediate", pal_rgb, 24'hAA0000);
    do_wr(7'h0B, 8'h00);

    // Write colliding with the commit edge stays in the working copy.
    do_wr(7'h07, 8'h22); do_wr(7'h0B, 8'h01); vsync_pulse();
    chk("top_first", vp_top, 10'h022);
    do_wr(7'h0B, 8'h01);
    vs_v = 1'b0; idle(2); do_wr(7'h07, 8'h55); idle(1);
    vs_v = 1'b1; idle(2);
    chk("top_edge_write_held", vp_top, 10'h022);
    do_rd(7'h0C); do_rd(7'h07);
    do_wr(7'h0B, 8'h01); vsync_pulse();
    chk("top_next_frame", vp_top, 10'h055);

    // COMMIT written on the edge itself re-arms for the following frame.
    do_wr(7'h03, 8'h99); do_wr(7'h0B, 8'h01);
    vs_v = 1'b0; idle(2); do_wr(7'h0B, 8'h01); idle(1);
    vs_v = 1'b1; idle(2);
    do_rd(7'h0C);
    vsync_pulse();
    chk("left_rearmed", vp_left, 10'h199);

    // vblank interrupt and write-one-to-clear.
    do_wr(7'h0F, 8'h01); vsync_pulse();
    chk("vblank_irq_set", irq, 1'b1);
    do_wr(7'h0C, 8'h04);
    chk("vblank_irq_clr", irq, 1'b0);
    do_wr(7'h0F, 8'h00);

`ifdef VIDEOCTL_RASTER_IRQ_EN
    do_wr(7'h0D, 8'h00); do_wr(7'h0E, 8'h03); do_wr(7'h0F, 8'h02);
    vsync_pulse();
    hsync_pulse(); hsync_pulse();
    chk("raster_before", irq, 1'b0);
    hsync_pulse();
    chk("raster_hit", irq, 1'b1);
    do_wr(7'h0C, 8'h04);
    chk("raster_clr", irq, 1'b0);
    // Saturation: the counter reaches all-ones once and then sticks.
    do_wr(7'h0D, 8'h03); do_wr(7'h0E, 8'hFF);
    vsync_pulse();
    for (int i = 0; i < 1023; i++) begin
      hs_v = 1'b0; idle(1);
      hs_v = 1'b1; idle(1);
    end
    idle(2);
    chk("raster_sat_hit", irq, 1'b1);
    do_wr(7'h0C, 8'h04);
    for (int i = 0; i < 5; i++) hsync_pulse();
    chk("raster_sat_stick", irq, 1'b0);
    do_wr(7'h0F, 8'h00);
`endif

    // Mid-frame reset abandons the pending commit.
    do_wr(7'h03, 8'h77); do_wr(7'h0B, 8'h01);
    do_reset();
    do_rd(7'h0C);
    do_wr(7'h03, 8'h44);
    do_wr(7'h0F, 8'h01); idle(3);
    chk("no_spurious_edge", irq, 1'b0);
    vsync_pulse();
    chk("reset_no_commit", vp_left, 10'h000);
    do_wr(7'h0C, 8'h04);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bit wr, rd;
      if ($urandom % 24 == 0) vs_v = ~vs_v;
      if ($urandom % 3 == 0)  hs_v = ~hs_v;
      pidx_v = 4'($urandom);
      wr = ($urandom % 3 == 0);
      rd = ($urandom % 3 == 0);
      cyc(wr, rd, pick_addr(), 8'($urandom));
    end

    vs_v = 1'b1; hs_v = 1'b1;
    idle(3);
    chk("rd_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/videoctl_regfile.md
Name: videoctl_regfile

Overview:
- Second-generation control/palette register bank for the video controller, clocked on the CPU register clock.
- Keeps a CPU-visible working copy and a display-visible active copy of the viewport, mode and palette registers.
- The working copy is committed atomically into the active copy at the start of vertical sync, giving tear-free updates.
- Adds byte readback, a status register and an interrupt source (vblank, optional raster line).

Parameters:
- ADDR_W, 7, register address width; the palette occupies the upper half (offset 2^(ADDR_W-1)).
- PAL_BITS, 4, log2 of the palette entry count; requires 3*2^PAL_BITS <= 2^(ADDR_W-1).
- COLOR_W, 8, bits per colour component (<= 8).
- POS_W, 10, width of viewport positions and the line counter (<= 16).

Ports:
- reg_clk, in, 1, clock.
- nreset, in, 1, synchronous active-low reset.
- reg_wr, in, 1, write strobe.
- reg_rd, in, 1, read strobe.
- reg_addr, in, ADDR_W, register address.
- reg_data, in, 8, write data.
- reg_q, out, 8, read data, registered.
- hsync_in, in, 1, async from the pixel domain, active low.
- vsync_in, in, 1, async from the pixel domain, active low.
- base_addr, out, 16, active base address.
- vp_left, out, POS_W, active viewport left.
- vp_right, out, POS_W, active viewport right.
- vp_top, out, POS_W, active viewport top.
- vp_bottom, out, POS_W, active viewport bottom.
- mode, out, 2, active display mode.
- hzoom_max, out, 2, active horizontal zoom.
- vzoom_max, out, 2, active vertical zoom.
- pal_idx, in, PAL_BITS, palette index from the pixel path.
- pal_rgb, out, 3*COLOR_W, active palette entry {r,g,b}; combinational from pal_idx.
- irq, out, 1, level interrupt, active high.

Behaviour:
- Interface: reset nreset, synchronous, active-low; clock reg_clk.
- Register map (working copy; multi-byte values are hi byte then lo byte):
  - 0x00/01 base.
  - 0x02/03 left.
  - 0x04/05 right.
  - 0x06/07 top.
  - 0x08/09 bottom.
  - 0x0A mode: [5:4] vzoom, [3:2] hzoom, [1:0] mode.
  - 0x0B CTL: bit0 COMMIT, bit1 IMMEDIATE.
  - 0x0C STATUS: bit0 pending, bit1 vblank (synchronised vsync low), bit2 irq_flag; write 1 to bit2 clears it.
  - 0x0D/0E raster compare line.
  - 0x0F IRQEN: bit0 vblank, bit1 raster.
  - Palette: red at P+i, green at P+2^PAL_BITS+i, blue at P+2*2^PAL_BITS+i, with P = 2^(ADDR_W-1).
- Hi-byte writes keep only bits [POS_W-9:0]; unused bits read back 0.
- Writes take effect in the working copy on the reg_clk edge with reg_wr high.
- Reads: reg_q is valid the cycle after reg_rd. It returns the working copy; STATUS is live. Unmapped addresses read 0x00. reg_q holds its value when reg_rd is low.
- Synchronisers: hsync_in and vsync_in each pass through 2 flops plus a falling-edge detector. The flops reset to 1, so no edge is seen after reset.
- Commit:
  - Writing CTL with bit0=1 sets pending; writing bit0=0 clears it.
  - On a vsync falling edge with pending=1, all active registers take the working values in one cycle and pending clears.
  - A register write in the same cycle as the edge is NOT committed; it stays in the working copy.
  - A COMMIT write in the same cycle as the edge sets pending for the next frame.
  - A vsync fall with pending=0 sets the vblank irq_flag source only.
- IMMEDIATE=1: active copy follows the working copy every cycle; pending is ignored.
- Line counter (POS_W bits):
  - Cleared on a vsync falling edge.
  - Incremented on each hsync falling edge, saturating at all-ones.
  - A vsync edge wins over an hsync edge in the same cycle.
- irq_flag:
  - Set on a vsync falling edge if IRQEN.0 is set.
  - Set when the line counter increments to equal the compare value and IRQEN.1 is set.
  - Set wins over a same-cycle clear.
  - irq = irq_flag.
- Reset: working and active copies 0, reg_q 0x00, pending 0, IMMEDIATE 0, irq_flag 0, line counter 0, irq 0. A mid-frame reset abandons any pending commit.

Optional Feature:
- VIDEOCTL_RASTER_IRQ_EN defined: line counter, compare registers 0x0D/0E and IRQEN.1 are present.
- Undefined: those are absent, 0x0D/0E and IRQEN.1 read 0, writes are ignored, and only the vblank interrupt exists.

Decomposition:
- Package videoctl_pkg: register offsets, CTL/STATUS/IRQEN bit indices, MODE_TEXT/1BPP/2BPP/4BPP constants.
- Sub-module sync_falling_edge: 2-flop synchroniser plus falling-edge pulse, reset to 1. Instantiated for hsync and vsync.

Test Plan:
- Reset, then read 0x00..0x0F and the palette -> all 0x00, irq=0, all outputs 0.
- Write left=0x12C (0x02=0x01, 0x03=0x2C), CTL=0x01 -> vp_left stays 0 and STATUS=0x01; after a vsync fall plus 3 clocks, vp_left=0x12C and STATUS.0=0.
- Write red[5]=0xAA with IMMEDIATE=1 -> pal_idx=5 gives pal_rgb=0xAA0000 within 1 clock, with no vsync needed.
- Write to 0x07 in the same cycle as the synchronised vsync edge, with pending=1 -> active vp_top keeps the old value; the new value commits at the next frame after a fresh COMMIT.
- (RASTER_IRQ_EN) compare=3, IRQEN=0x02; vsync fall then 3 hsync falls -> irq rises after the 3rd. Write STATUS=0x04 -> irq=0.
- Pulse reset with pending=1 mid-frame -> pending=0; no commit at the next vsync; no spurious edge is detected immediately after reset.
